// File: rtl/present_pkg.sv
// Shared PRESENT constants, FSM encodings and S-box/key-schedule helpers
// (used by both the encryption and decryption cores).
package present_pkg;

   localparam int NROUNDS = 31;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_EXPAND = 2'd1;
   localparam logic [1:0] S_WHITEN = 2'd2;
   localparam logic [1:0] S_ROUND  = 2'd3;

   function automatic logic [3:0] sbox4(input logic [3:0] x);
      case (x)
         4'h0: sbox4 = 4'hC;  4'h1: sbox4 = 4'h5;  4'h2: sbox4 = 4'h6;  4'h3: sbox4 = 4'hB;
         4'h4: sbox4 = 4'h9;  4'h5: sbox4 = 4'h0;  4'h6: sbox4 = 4'hA;  4'h7: sbox4 = 4'hD;
         4'h8: sbox4 = 4'h3;  4'h9: sbox4 = 4'hE;  4'hA: sbox4 = 4'hF;  4'hB: sbox4 = 4'h8;
         4'hC: sbox4 = 4'h4;  4'hD: sbox4 = 4'h7;  4'hE: sbox4 = 4'h1;  4'hF: sbox4 = 4'h2;
         default: sbox4 = 4'h0;
      endcase
   endfunction

   function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
      case (x)
         4'h0: inv_sbox4 = 4'h5;  4'h1: inv_sbox4 = 4'hE;  4'h2: inv_sbox4 = 4'hF;  4'h3: inv_sbox4 = 4'h8;
         4'h4: inv_sbox4 = 4'hC;  4'h5: inv_sbox4 = 4'h1;  4'h6: inv_sbox4 = 4'h2;  4'h7: inv_sbox4 = 4'hD;
         4'h8: inv_sbox4 = 4'hB;  4'h9: inv_sbox4 = 4'h4;  4'hA: inv_sbox4 = 4'h6;  4'hB: inv_sbox4 = 4'h3;
         4'hC: inv_sbox4 = 4'h0;  4'hD: inv_sbox4 = 4'h7;  4'hE: inv_sbox4 = 4'h9;  4'hF: inv_sbox4 = 4'hA;
         default: inv_sbox4 = 4'h0;
      endcase
   endfunction

   // forward key update: rotl 61, S-box on top nibble, round counter into [19:15]
   function automatic logic [79:0] key_fwd(input logic [79:0] k, input logic [4:0] rc);
      logic [79:0] t;
      t          = {k[18:0], k[79:19]};
      t[79:76]   = sbox4(t[79:76]);
      t[19:15]   = t[19:15] ^ rc;
      key_fwd    = t;
   endfunction

   function automatic logic [79:0] key_inv(input logic [79:0] k, input logic [4:0] rc);
      logic [79:0] t;
      t          = k;
      t[19:15]   = t[19:15] ^ rc;
      t[79:76]   = inv_sbox4(t[79:76]);
      key_inv    = {t[60:0], t[79:61]};
   endfunction

endpackage

// File: rtl/present_inv_perm.sv
// Inverse PRESENT pLayer; pure wiring. The permutation is symmetric under
// bit-order reversal, so the same formula holds for MSB-first numbering.
module present_inv_perm (
   input  logic [0:63] din,
   output logic [0:63] dout
);

   for (genvar k = 0; k < 64; k++) begin : g_bit
      assign dout[k] = din[(k % 4) * 16 + k / 4];
   end

endmodule

// File: rtl/present80_dec.sv
// Iterative PRESENT-80 decryption core, one round per clock.
// Optional K32 key cache: define PRESENT80_DEC_KEYCACHE_EN.
module present80_dec
   import present_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         new_key,
   input  logic [0:63]  ct_in,
   input  logic [79:0]  key_in,
   output logic [0:63]  pt_out,
   output logic         busy,
   output logic         done
);

   logic [1:0]  state_r;
   logic [4:0]  cnt_r;
   logic [0:63] st_r;
   logic [79:0] kr_r;
   logic [0:63] perm_s;
   logic [0:63] invs_s;
   logic [0:63] st_round_s;
   logic [79:0] kr_fwd_s;
   logic [79:0] kr_inv_s;

   present_inv_perm u_inv_perm (
      .din  (st_r),
      .dout (perm_s)
   );

   // inverse S-box layer, next round key and round result
   always_comb begin
      invs_s = '0;
      for (int j = 0; j < 16; j++) begin
         invs_s[4*j +: 4] = inv_sbox4(perm_s[4*j +: 4]);
      end
      kr_fwd_s   = key_fwd(kr_r, cnt_r);
      kr_inv_s   = key_inv(kr_r, cnt_r);
      st_round_s = invs_s ^ kr_inv_s[79:16];
   end

`ifdef PRESENT80_DEC_KEYCACHE_EN
   logic [79:0] cache_r;
   logic        cache_valid_r;

   // capture K32 when the forward expansion completes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cache_r       <= 80'd0;
         cache_valid_r <= 1'b0;
      end else if (state_r == S_EXPAND && cnt_r == 5'd31) begin
         cache_r       <= kr_fwd_s;
         cache_valid_r <= 1'b1;
      end else begin
         cache_r       <= cache_r;
         cache_valid_r <= cache_valid_r;
      end
   end
`else
   logic unused_new_key_s;
   assign unused_new_key_s = new_key;
`endif

   // control FSM and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= S_IDLE;
         cnt_r   <= 5'd0;
         st_r    <= 64'd0;
         kr_r    <= 80'd0;
         pt_out  <= 64'd0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (start) begin
                  st_r  <= ct_in;
                  cnt_r <= 5'd1;
                  busy  <= 1'b1;
`ifdef PRESENT80_DEC_KEYCACHE_EN
                  if (!new_key && cache_valid_r) begin
                     kr_r    <= cache_r;
                     state_r <= S_WHITEN;
                  end else begin
                     kr_r    <= key_in;
                     state_r <= S_EXPAND;
                  end
`else
                  kr_r    <= key_in;
                  state_r <= S_EXPAND;
`endif
               end
            end
            S_EXPAND: begin
               kr_r <= kr_fwd_s;
               if (cnt_r == 5'd31) begin
                  state_r <= S_WHITEN;
               end else begin
                  cnt_r <= cnt_r + 5'd1;
               end
            end
            S_WHITEN: begin
               st_r    <= st_r ^ kr_r[79:16];
               cnt_r   <= 5'd31;
               state_r <= S_ROUND;
            end
            S_ROUND: begin
               st_r <= st_round_s;
               kr_r <= kr_inv_s;
               if (cnt_r == 5'd1) begin
                  pt_out  <= st_round_s;
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state_r <= S_IDLE;
               end else begin
                  cnt_r <= cnt_r - 5'd1;
               end
            end
            default: begin
               state_r <= S_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
